// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Consumed by bcd2bin_seq and its sub3 nibble corrector.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BCD_MAX_DIGIT = 9;
    localparam int unsigned BIN_MAX       = 255;
    localparam int unsigned DABBLE_THRESH = 8;
    localparam int unsigned DABBLE_CORR   = 3;

    // True when the three digits are not valid BCD or their decimal value overflows 8 bits.
    function automatic logic bcd_out_of_range(input logic [1:0] h,
                                              input logic [3:0] t,
                                              input logic [3:0] o);
        int unsigned hv;
        int unsigned tv;
        int unsigned ov;
        int unsigned dec;
        hv  = 32'(h);
        tv  = 32'(t);
        ov  = 32'(o);
        dec = hv * 100 + tv * 10 + ov;
        return (tv > BCD_MAX_DIGIT) || (ov > BCD_MAX_DIGIT) || (dec > BIN_MAX);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_sub3.sv
// Reverse double-dabble correction cell: subtract 3 from a BCD nibble that reached 8 or more.
// Mirror of the add-3 cell used by the binary-to-BCD direction.
module sub3
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    always_comb begin
        if (i_nib >= 4'(DABBLE_THRESH)) begin
            o_nib = i_nib - 4'(DABBLE_CORR);
        end else begin
            o_nib = i_nib;
        end
    end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter, one reverse double-dabble step per clock.
// Optional operand range checking is enabled by defining BCD2BIN_RANGE_CHECK_EN.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       HUNDREDS,
    input  logic [3:0]       TENS,
    input  logic [3:0]       ONES,
    output logic             ready,
    output logic             valid,
    output logic [BIN_W-1:0] B,
    output logic             err
);

    localparam int unsigned BCD_W = 12;
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    state_t           r_state;
    logic [BCD_W-1:0] r_bcd;
    logic [BIN_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [BIN_W-1:0] r_b;
    logic             r_err;
    logic             r_err_pend;

    logic [SR_W-1:0]  w_shift;
    logic [BCD_W-1:0] w_bcd_next;
    logic             w_range_err;
    logic             w_last_iter;

    // Shift the combined {bcd, binary} register right; the BCD nibbles are then corrected.
    assign w_shift     = {r_bcd, r_acc} >> 1;
    assign w_last_iter = (r_cnt == CNT_W'(BIN_W - 1));

    sub3 u_sub3_ones (
        .i_nib (w_shift[BIN_W+3:BIN_W]),
        .o_nib (w_bcd_next[3:0])
    );

    sub3 u_sub3_tens (
        .i_nib (w_shift[BIN_W+7:BIN_W+4]),
        .o_nib (w_bcd_next[7:4])
    );

    sub3 u_sub3_hund (
        .i_nib (w_shift[BIN_W+11:BIN_W+8]),
        .o_nib (w_bcd_next[11:8])
    );

`ifdef BCD2BIN_RANGE_CHECK_EN
    assign w_range_err = bcd_out_of_range(HUNDREDS, TENS, ONES);
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bcd      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_b        <= '0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd      <= {2'b00, HUNDREDS, TENS, ONES};
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_err_pend <= w_range_err;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= w_bcd_next;
                    r_acc <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_iter) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_b     <= r_err_pend ? '0 : r_acc;
                    r_err   <= r_err_pend;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign valid = r_valid;
    assign B     = r_b;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed table, held-start, reset abort, sweep and random.
// Expected results come from decimal arithmetic on the digits.
module tb_bcd2bin_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ready;
    logic       valid;
    logic [7:0] b_out;
    logic       err;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_b = 8'h00;

    typedef struct {
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic [7:0] b;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    bcd2bin_seq #(.BIN_W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .HUNDREDS (hund),
        .TENS     (tens),
        .ONES     (ones),
        .ready    (ready),
        .valid    (valid),
        .B        (b_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal value of the digits, wrapped to 8 bits.
    function automatic void model(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                                  output logic [7:0] eb, output logic ee);
        int unsigned dec;
        logic bad;
        dec = 32'(h) * 100 + 32'(t) * 10 + 32'(o);
        bad = (t > 4'd9) || (o > 4'd9) || (dec > 255);
`ifdef BCD2BIN_RANGE_CHECK_EN
        ee = bad;
        eb = bad ? 8'h00 : dec[7:0];
`else
        ee = 1'b0;
        eb = dec[7:0];
`endif
    endfunction

    task automatic run_one(input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [7:0] eb, input logic ee, input string name);
        int lat;
        int rdy_low;
        check({name, "_ready_idle"}, ready, 1'b1);
        hund  = h;
        tens  = t;
        ones  = o;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        hund    = 2'(~h);
        tens    = ~t;
        ones    = ~o;
        check({name, "_valid_low"}, valid, 1'b0);
        check({name, "_B_held"}, b_out, last_b);
        rdy_low = ready ? 0 : 1;
        lat     = 0;
        while (!valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!ready) rdy_low++;
        end
        check({name, "_latency"}, lat, 9);
        check({name, "_ready_low_cycles"}, rdy_low, 9);
        check({name, "_B"}, b_out, eb);
        check({name, "_err"}, err, ee);
        last_b = b_out;
    endtask

    initial begin
        logic [7:0] eb;
        logic       ee;
        logic [1:0] dh[40];
        logic [3:0] dt[40];
        logic [3:0] dox[40];
        logic [7:0] pend_b;
        int         vcount;

        rst   = 1'b1;
        start = 1'b0;
        hund  = '0;
        tens  = '0;
        ones  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_B", b_out, 8'h00);
        check("rst_err", err, 1'b0);
        rst = 1'b0;

        vecs.push_back('{2'd0, 4'd0, 4'd0, 8'h00, 1'b0});
        vecs.push_back('{2'd2, 4'd5, 4'd5, 8'hFF, 1'b0});
        vecs.push_back('{2'd1, 4'd0, 4'd0, 8'h64, 1'b0});
        vecs.push_back('{2'd0, 4'd9, 4'd9, 8'h63, 1'b0});
        vecs.push_back('{2'd1, 4'd2, 4'd8, 8'h80, 1'b0});
        vecs.push_back('{2'd0, 4'd0, 4'd1, 8'h01, 1'b0});
`ifdef BCD2BIN_RANGE_CHECK_EN
        vecs.push_back('{2'd2, 4'd5, 4'd6, 8'h00, 1'b1});
        vecs.push_back('{2'd0, 4'hA, 4'd0, 8'h00, 1'b1});
        vecs.push_back('{2'd0, 4'd3, 4'hF, 8'h00, 1'b1});
        vecs.push_back('{2'd2, 4'd6, 4'd0, 8'h00, 1'b1});
        vecs.push_back('{2'd3, 4'd0, 4'd0, 8'h00, 1'b1});
`else
        vecs.push_back('{2'd2, 4'd5, 4'd6, 8'h00, 1'b0});
        vecs.push_back('{2'd3, 4'd0, 4'd0, 8'h2C, 1'b0});
`endif
        foreach (vecs[i]) run_one(vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].b, vecs[i].e, "table");

        // start held high: only every 10th cycle's digits are accepted
        for (int k = 0; k < 40; k++) begin
            int unsigned v;
            v      = $urandom_range(0, 255);
            dh[k]  = 2'(v / 100);
            dt[k]  = 4'((v / 10) % 10);
            dox[k] = 4'(v % 10);
        end
        pend_b = 8'h00;
        for (int k = 0; k < 40; k++) begin
            hund  = dh[k];
            tens  = dt[k];
            ones  = dox[k];
            start = 1'b1;
            if (k % 10 == 0) model(dh[k], dt[k], dox[k], pend_b, ee);
            @(posedge clk);
            #1;
            check("hold_valid", valid, (k % 10 == 9) ? 1'b1 : 1'b0);
            if (k % 10 == 9) begin
                check("hold_B", b_out, pend_b);
                last_b = pend_b;
            end else begin
                check("hold_B_held", b_out, last_b);
            end
        end
        start = 1'b0;

        // reset four cycles into a conversion aborts it
        hund  = 2'd1;
        tens  = 4'd7;
        ones  = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", ready, 1'b1);
        check("abort_valid", valid, 1'b0);
        check("abort_B", b_out, 8'h00);
        check("abort_err", err, 1'b0);
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        last_b = 8'h00;
        run_one(2'd1, 4'd7, 4'd3, 8'd173, 1'b0, "after_abort");

        for (int v = 0; v < 256; v++) begin
            logic [1:0] h;
            logic [3:0] t;
            logic [3:0] o;
            h = 2'(v / 100);
            t = 4'((v / 10) % 10);
            o = 4'(v % 10);
            model(h, t, o, eb, ee);
            run_one(h, t, o, eb, ee, "sweep");
        end

        for (int n = 0; n < 60; n++) begin
            int unsigned v;
            logic [1:0] h;
            logic [3:0] t;
            logic [3:0] o;
            v = $urandom_range(0, 399);
            h = 2'(v / 100);
            t = 4'((v / 10) % 10);
            o = 4'(v % 10);
`ifdef BCD2BIN_RANGE_CHECK_EN
            if ($urandom_range(0, 3) == 0) begin
                t = 4'($urandom_range(0, 15));
                o = 4'($urandom_range(0, 15));
            end
`endif
            model(h, t, o, eb, ee);
            run_one(h, t, o, eb, ee, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
